// File: rtl/vend_ctrl_param.sv
// Parametrised single-product vending controller. It handles coin credit, dispense
// with change, cancel/refund, coin rejection, and stock tracking with restock.
module vend_ctrl_param #(
  parameter int  PRICE      = 4,
  parameter int  MAX_CREDIT = 15,
  parameter int  STOCK_INIT = 8,
  localparam int CW         = $clog2(MAX_CREDIT + 1),
  localparam int SW         = $clog2(STOCK_INIT + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_nickel,
  input  logic          i_dime,
  input  logic          i_quarter,
  input  logic          i_cancel,
  input  logic          i_restock,
  output logic          o_soda,
  output logic [CW-1:0] o_change,
  output logic          o_refund,
  output logic          o_coin_reject,
  output logic [CW-1:0] o_credit,
  output logic          o_empty
);

  // One bit above CW so credit+coin never wraps, and at least wide enough for a quarter
  localparam int AW = (CW + 1 > 3) ? CW + 1 : 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_REFUND   = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] credit_r;
  logic [CW-1:0] credit_nxt_s;
  logic [SW-1:0] stock_r;
  logic [SW-1:0] stock_nxt_s;
  logic          soda_r;
  logic          soda_nxt_s;
  logic          refund_r;
  logic          refund_nxt_s;
  logic          reject_r;
  logic          reject_nxt_s;
  logic [CW-1:0] change_r;
  logic [CW-1:0] change_nxt_s;

  logic [AW-1:0] coin_val_s;
  logic [AW-1:0] sum_s;
  logic          any_coin_s;
  logic          open_s;
  logic          accept_s;
  logic          cancel_s;
  logic          reach_price_s;

  // Decode the coin strobes; anything other than exactly one strobe is worth nothing
  always_comb begin
    coin_val_s = {AW{1'b0}};
    case ({i_quarter, i_dime, i_nickel})
      3'b001:  coin_val_s = AW'(1);
      3'b010:  coin_val_s = AW'(2);
      3'b100:  coin_val_s = AW'(5);
      default: coin_val_s = {AW{1'b0}};
    endcase
  end

  assign any_coin_s    = i_nickel | i_dime | i_quarter;
  assign sum_s         = {{(AW-CW){1'b0}}, credit_r} + coin_val_s;
  assign open_s        = (state_r == ST_IDLE) || (state_r == ST_COLLECT);
  assign cancel_s      = i_cancel && (state_r == ST_COLLECT);
  assign reach_price_s = (sum_s >= AW'(PRICE));
  assign accept_s      = (coin_val_s != {AW{1'b0}}) && open_s && !i_cancel &&
                         (stock_r != {SW{1'b0}}) && (sum_s <= AW'(MAX_CREDIT));

  // State register plus the registered datapath and outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r  <= ST_IDLE;
      credit_r <= {CW{1'b0}};
      stock_r  <= SW'(STOCK_INIT);
      soda_r   <= 1'b0;
      refund_r <= 1'b0;
      reject_r <= 1'b0;
      change_r <= {CW{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      credit_r <= credit_nxt_s;
      stock_r  <= stock_nxt_s;
      soda_r   <= soda_nxt_s;
      refund_r <= refund_nxt_s;
      reject_r <= reject_nxt_s;
      change_r <= change_nxt_s;
    end
  end

  // Next-state logic; cancel outranks a coin offered in the same cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_COLLECT: begin
        if (cancel_s) begin
          state_nxt_s = ST_REFUND;
        end else if (accept_s) begin
          state_nxt_s = reach_price_s ? ST_DISPENSE : ST_COLLECT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DISPENSE: state_nxt_s = ST_IDLE;
      ST_REFUND:   state_nxt_s = ST_IDLE;
      default:     state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values for credit, stock and the pulsed outputs
  always_comb begin
    credit_nxt_s = credit_r;
    stock_nxt_s  = stock_r;
    soda_nxt_s   = 1'b0;
    refund_nxt_s = 1'b0;
    change_nxt_s = {CW{1'b0}};
    reject_nxt_s = any_coin_s && !accept_s;
    case (state_r)
      ST_IDLE, ST_COLLECT: begin
        if (i_restock) begin
          stock_nxt_s = SW'(STOCK_INIT);
        end else begin
          stock_nxt_s = stock_r;
        end
        if (cancel_s) begin
          refund_nxt_s = 1'b1;
          change_nxt_s = credit_r;
        end else if (accept_s) begin
          // An accepted sum never exceeds MAX_CREDIT, so it fits in CW bits
          credit_nxt_s = sum_s[CW-1:0];
          if (reach_price_s) begin
            soda_nxt_s   = 1'b1;
            change_nxt_s = sum_s[CW-1:0] - CW'(PRICE);
          end else begin
            soda_nxt_s   = 1'b0;
          end
        end else begin
          credit_nxt_s = credit_r;
        end
      end
      ST_DISPENSE: begin
        credit_nxt_s = {CW{1'b0}};
        stock_nxt_s  = stock_r - SW'(1);
      end
      ST_REFUND: begin
        credit_nxt_s = {CW{1'b0}};
      end
      default: begin
        credit_nxt_s = {CW{1'b0}};
      end
    endcase
  end

  assign o_soda        = soda_r;
  assign o_refund      = refund_r;
  assign o_coin_reject = reject_r;
  assign o_change      = change_r;
  assign o_credit      = credit_r;
  assign o_empty       = (stock_r == {SW{1'b0}});

  vend_ctrl_param_chk #(
    .PRICE      (PRICE),
    .MAX_CREDIT (MAX_CREDIT),
    .CW         (CW)
  ) u_chk (
    .clk    (i_clk),
    .rst    (i_rst),
    .soda   (o_soda),
    .refund (o_refund),
    .change (o_change),
    .credit (o_credit)
  );

endmodule

// Output invariants of the vending controller.
module vend_ctrl_param_chk #(
  parameter int PRICE      = 4,
  parameter int MAX_CREDIT = 15,
  parameter int CW         = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          soda,
  input logic          refund,
  input logic [CW-1:0] change,
  input logic [CW-1:0] credit
);

  a_soda_refund_excl: assert property (@(posedge clk) disable iff (rst)
    !(soda && refund));

  a_change_only_when_valid: assert property (@(posedge clk) disable iff (rst)
    (!soda && !refund) |-> (change == {CW{1'b0}}));

  a_change_bound: assert property (@(posedge clk) disable iff (rst)
    soda |-> (change <= CW'(MAX_CREDIT - PRICE)));

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    credit <= CW'(MAX_CREDIT));

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Scoreboard bench for vend_ctrl_param: three instances cover default pricing,
// a single-can stock, and a price close to the credit ceiling.
module tb_vend_ctrl_param;

  typedef struct packed {
    logic       soda;
    logic [3:0] change;
    logic       refund;
    logic       reject;
    logic [3:0] credit;
    logic       empty;
  } obs_t;

  localparam logic [4:0] S_IDLE = 5'b00000;
  localparam logic [4:0] S_N    = 5'b00001;
  localparam logic [4:0] S_D    = 5'b00010;
  localparam logic [4:0] S_Q    = 5'b00100;
  localparam logic [4:0] S_C    = 5'b01000;
  localparam logic [4:0] S_R    = 5'b10000;

  logic       clk;
  logic       rst     [3];
  logic       nickel  [3];
  logic       dime    [3];
  logic       quarter [3];
  logic       cancel  [3];
  logic       restock [3];
  logic       soda    [3];
  logic [3:0] change  [3];
  logic       refund  [3];
  logic       reject  [3];
  logic [3:0] credit  [3];
  logic       empty   [3];

  obs_t exp_q [$];
  obs_t got_q [$];
  int   n_checks;
  int   n_errors;

  vend_ctrl_param u_dut_a (
    .i_clk(clk), .i_rst(rst[0]), .i_nickel(nickel[0]), .i_dime(dime[0]),
    .i_quarter(quarter[0]), .i_cancel(cancel[0]), .i_restock(restock[0]),
    .o_soda(soda[0]), .o_change(change[0]), .o_refund(refund[0]),
    .o_coin_reject(reject[0]), .o_credit(credit[0]), .o_empty(empty[0])
  );

  vend_ctrl_param #(.STOCK_INIT(1)) u_dut_b (
    .i_clk(clk), .i_rst(rst[1]), .i_nickel(nickel[1]), .i_dime(dime[1]),
    .i_quarter(quarter[1]), .i_cancel(cancel[1]), .i_restock(restock[1]),
    .o_soda(soda[1]), .o_change(change[1]), .o_refund(refund[1]),
    .o_coin_reject(reject[1]), .o_credit(credit[1]), .o_empty(empty[1])
  );

  vend_ctrl_param #(.PRICE(10), .MAX_CREDIT(12)) u_dut_c (
    .i_clk(clk), .i_rst(rst[2]), .i_nickel(nickel[2]), .i_dime(dime[2]),
    .i_quarter(quarter[2]), .i_cancel(cancel[2]), .i_restock(restock[2]),
    .o_soda(soda[2]), .o_change(change[2]), .o_refund(refund[2]),
    .o_coin_reject(reject[2]), .o_credit(credit[2]), .o_empty(empty[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic obs_t mk(input logic s, input int ch, input logic r,
                              input logic j, input int cr, input logic e);
    obs_t o;
    o.soda   = s;
    o.change = 4'(ch);
    o.refund = r;
    o.reject = j;
    o.credit = 4'(cr);
    o.empty  = e;
    return o;
  endfunction

  function automatic obs_t sample(input int d);
    obs_t o;
    o.soda   = soda[d];
    o.change = change[d];
    o.refund = refund[d];
    o.reject = reject[d];
    o.credit = credit[d];
    o.empty  = empty[d];
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("soda=%0b change=%0d refund=%0b reject=%0b credit=%0d empty=%0b",
                     o.soda, o.change, o.refund, o.reject, o.credit, o.empty);
  endfunction

  // Drive one cycle of stimulus, queue its expectation, capture the response
  task automatic apply(input int d, input logic [4:0] stim, input obs_t exp);
    {restock[d], cancel[d], quarter[d], dime[d], nickel[d]} = stim;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    got_q.push_back(sample(d));
    {restock[d], cancel[d], quarter[d], dime[d], nickel[d]} = 5'b00000;
  endtask

  task automatic test_reset();
    obs_t e, g;
    int idx = 0;
    for (int d = 0; d < 3; d++) begin
      exp_q.push_back(mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b0));
      got_q.push_back(sample(d));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_errors++;
        $display("FAIL reset #%0d: got %s, expected %s", idx, fmt(g), fmt(e));
      end
      idx++;
    end
  endtask

  task automatic test_vend_basic();
    obs_t e, g;
    int idx = 0;
    apply(0, S_D,    mk(1'b0, 0, 1'b0, 1'b0, 2, 1'b0));
    apply(0, S_Q,    mk(1'b1, 3, 1'b0, 1'b0, 7, 1'b0));
    apply(0, S_IDLE, mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b0));
    apply(0, S_N,    mk(1'b0, 0, 1'b0, 1'b0, 1, 1'b0));
    apply(0, S_D,    mk(1'b0, 0, 1'b0, 1'b0, 3, 1'b0));
    apply(0, S_Q,    mk(1'b1, 4, 1'b0, 1'b0, 8, 1'b0));
    apply(0, S_Q,    mk(1'b0, 0, 1'b0, 1'b1, 0, 1'b0));
    apply(0, S_IDLE, mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_errors++;
        $display("FAIL vend_basic #%0d: got %s, expected %s", idx, fmt(g), fmt(e));
      end
      idx++;
    end
  endtask

  task automatic test_cancel();
    obs_t e, g;
    int idx = 0;
    apply(0, S_D,       mk(1'b0, 0, 1'b0, 1'b0, 2, 1'b0));
    apply(0, S_C,       mk(1'b0, 2, 1'b1, 1'b0, 2, 1'b0));
    apply(0, S_IDLE,    mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b0));
    apply(0, S_C,       mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b0));
    apply(0, S_C,       mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b0));
    apply(0, S_N,       mk(1'b0, 0, 1'b0, 1'b0, 1, 1'b0));
    apply(0, S_C | S_D, mk(1'b0, 1, 1'b1, 1'b1, 1, 1'b0));
    apply(0, S_IDLE,    mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_errors++;
        $display("FAIL cancel #%0d: got %s, expected %s", idx, fmt(g), fmt(e));
      end
      idx++;
    end
  endtask

  task automatic test_stock();
    obs_t e, g;
    int idx = 0;
    apply(1, S_Q,    mk(1'b1, 1, 1'b0, 1'b0, 5, 1'b0));
    apply(1, S_IDLE, mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b1));
    apply(1, S_N,    mk(1'b0, 0, 1'b0, 1'b1, 0, 1'b1));
    apply(1, S_R,    mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b0));
    apply(1, S_N,    mk(1'b0, 0, 1'b0, 1'b0, 1, 1'b0));
    apply(1, S_Q,    mk(1'b1, 2, 1'b0, 1'b0, 6, 1'b0));
    apply(1, S_R,    mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b1));
    apply(1, S_IDLE, mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b1));
    apply(1, S_R,    mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_errors++;
        $display("FAIL stock #%0d: got %s, expected %s", idx, fmt(g), fmt(e));
      end
      idx++;
    end
  endtask

  task automatic test_ceiling();
    obs_t e, g;
    int idx = 0;
    for (int i = 1; i <= 4; i++) begin
      apply(2, S_D, mk(1'b0, 0, 1'b0, 1'b0, 2 * i, 1'b0));
    end
    apply(2, S_Q,    mk(1'b0, 0, 1'b0, 1'b1, 8, 1'b0));
    apply(2, S_D,    mk(1'b1, 0, 1'b0, 1'b0, 10, 1'b0));
    apply(2, S_IDLE, mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_errors++;
        $display("FAIL ceiling #%0d: got %s, expected %s", idx, fmt(g), fmt(e));
      end
      idx++;
    end
  endtask

  task automatic test_invalid_coin();
    obs_t e, g;
    int idx = 0;
    apply(0, S_D | S_N,       mk(1'b0, 0, 1'b0, 1'b1, 0, 1'b0));
    apply(0, S_Q | S_D | S_N, mk(1'b0, 0, 1'b0, 1'b1, 0, 1'b0));
    apply(0, S_IDLE,          mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_errors++;
        $display("FAIL invalid_coin #%0d: got %s, expected %s", idx, fmt(g), fmt(e));
      end
      idx++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, g;
    int idx = 0;
    apply(0, S_Q,    mk(1'b1, 1, 1'b0, 1'b0, 5, 1'b0));
    apply(0, S_Q,    mk(1'b0, 0, 1'b0, 1'b1, 0, 1'b0));
    apply(0, S_Q,    mk(1'b1, 1, 1'b0, 1'b0, 5, 1'b0));
    apply(0, S_IDLE, mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_errors++;
        $display("FAIL back_to_back #%0d: got %s, expected %s", idx, fmt(g), fmt(e));
      end
      idx++;
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, g;
    int idx = 0;
    apply(0, S_D, mk(1'b0, 0, 1'b0, 1'b0, 2, 1'b0));
    apply(0, S_N, mk(1'b0, 0, 1'b0, 1'b0, 3, 1'b0));
    #2;
    rst[0] = 1'b1;
    #1;
    exp_q.push_back(mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b0));
    got_q.push_back(sample(0));
    @(posedge clk);
    #1;
    exp_q.push_back(mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b0));
    got_q.push_back(sample(0));
    rst[0] = 1'b0;
    apply(0, S_N, mk(1'b0, 0, 1'b0, 1'b0, 1, 1'b0));
    // Drain the single-can instance, then reset must restore its stock
    apply(1, S_Q,    mk(1'b1, 1, 1'b0, 1'b0, 5, 1'b0));
    apply(1, S_IDLE, mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b1));
    #2;
    rst[1] = 1'b1;
    #1;
    exp_q.push_back(mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b0));
    got_q.push_back(sample(1));
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    apply(1, S_N, mk(1'b0, 0, 1'b0, 1'b0, 1, 1'b0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_errors++;
        $display("FAIL reset_mid #%0d: got %s, expected %s", idx, fmt(g), fmt(e));
      end
      idx++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int d = 0; d < 3; d++) begin
      rst[d]     = 1'b1;
      nickel[d]  = 1'b0;
      dime[d]    = 1'b0;
      quarter[d] = 1'b0;
      cancel[d]  = 1'b0;
      restock[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b0;
    end
    test_vend_basic();
    test_cancel();
    test_stock();
    test_ceiling();
    test_invalid_coin();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_param.md
Name: vend_ctrl_param

Overview:
- Parametrised single-product soda vending controller. Generalises the fixed-price coin machine: configurable price, credit ceiling and stock depth.
- Adds cancel/refund, coin rejection, stock tracking and restock.
- Sits between the coin-acceptor front end (one-cycle coin strobes) and the dispense/change actuators.
- All money is counted in nickel units (5 cents).

Parameters:
- PRICE, 4, product price in nickels (4 = 20 cents); legal range 1..MAX_CREDIT.
- MAX_CREDIT, 15, highest credit the machine holds, in nickels.
- STOCK_INIT, 8, number of cans loaded at reset and on restock; must be at least 1.
- CW (derived localparam), $clog2(MAX_CREDIT+1), width of the credit and change fields.
- SW (derived localparam), $clog2(STOCK_INIT+1), width of the stock counter.

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_nickel  in  1  coin strobe, value 1 nickel; each high cycle counts as one coin.
- i_dime  in  1  coin strobe, value 2 nickels.
- i_quarter  in  1  coin strobe, value 5 nickels.
- i_cancel  in  1  refund request, sampled every cycle.
- i_restock  in  1  reload request; sets stock to STOCK_INIT.
- o_soda  out  1  one-cycle dispense pulse.
- o_change  out  CW  change or refund amount in nickels; valid only while o_soda or o_refund is high, 0 otherwise.
- o_refund  out  1  one-cycle refund pulse.
- o_coin_reject  out  1  one-cycle pulse: the coin offered in the previous cycle was returned, not credited.
- o_credit  out  CW  current credit in nickels.
- o_empty  out  1  high when stock = 0.

Behaviour:
- Reset values (asynchronous): state=IDLE, credit=0, stock=STOCK_INIT. Outputs: o_soda=0, o_change=0, o_refund=0, o_coin_reject=0, o_credit=0, o_empty=0.
- States:
  - IDLE: credit=0.
  - COLLECT: 0 < credit < PRICE.
  - DISPENSE: one cycle.
  - REFUND: one cycle.
- Coin validity: a cycle is a "valid coin" cycle when exactly one strobe is high. If two or more strobes are high, it is an invalid coin: o_coin_reject=1 next cycle and credit is unchanged.
- Coin accepted only if all of the following hold; otherwise o_coin_reject pulses the next cycle:
  - state is IDLE or COLLECT;
  - i_cancel=0;
  - stock>0;
  - credit+value <= MAX_CREDIT.
- Accepted coin at edge N: credit <= credit+value, visible on o_credit after edge N.
  - If the new credit >= PRICE, state <= DISPENSE; otherwise state <= COLLECT.
- DISPENSE cycle (registered outputs): o_soda=1 and o_change=credit-PRICE for exactly one cycle.
  - Next edge: credit <= 0, stock <= stock-1, state <= IDLE.
  - Coins offered during DISPENSE are rejected. Cancel during DISPENSE is ignored.
- Latency: the completing coin is sampled at edge N, o_soda is high from edge N to edge N+1, and a new coin is accepted from edge N+2 sampling onward.
- Cancel:
  - In COLLECT: state <= REFUND. In the REFUND cycle, o_refund=1 and o_change=credit; then credit <= 0 and state <= IDLE.
  - In IDLE: ignored, no refund pulse.
  - Cancel with a coin in the same cycle: cancel wins, the coin is rejected, and the refund covers only the prior credit.
- Stock:
  - o_empty = (stock==0), combinational from the register.
  - When empty, all coins are rejected and no credit accrues.
- Restock:
  - Accepted only in IDLE or COLLECT: stock <= STOCK_INIT; credit is unaffected.
  - Ignored in DISPENSE and REFUND; the requester must hold or retry.
- Width rules: all arithmetic is done at CW+1 bits so the overflow compare never wraps. o_change never exceeds MAX_CREDIT-PRICE.
- Reset mid-operation: credit is discarded with no refund pulse; stock returns to STOCK_INIT.
- o_soda and o_refund are never high in the same cycle.

Test Plan:
- Defaults, dime then quarter on consecutive cycles -> credit 2 then 7; o_soda=1 for one cycle with o_change=3; then credit=0, stock=7.
- Nickel, dime, quarter -> credit 1, 3, 8; o_soda with o_change=4. Quarter offered during the DISPENSE cycle -> o_coin_reject next cycle, credit stays 0.
- Dime then i_cancel -> REFUND cycle with o_refund=1, o_change=2; then credit=0. Cancel held in IDLE -> no pulse.
- STOCK_INIT=1: vend once -> o_empty=1; nickel -> rejected. i_restock in IDLE -> o_empty=0, the next nickel is credited.
- PRICE=10, MAX_CREDIT=12: dime x4 (credit 8), then quarter -> rejected (13>12), credit stays 8; then dime -> credit 10, o_soda with o_change=0.
- Dime+nickel in the same cycle -> reject, credit 0. Assert i_rst asynchronously mid-COLLECT with credit 3 -> outputs 0 immediately, no refund, stock=STOCK_INIT.
